// File: rtl/axi_bw_rr_scheduler_if.sv
// rtl/axi_bw_rr_scheduler_if.sv - B-channel requester/response bus bundle for the round-robin scheduler
interface axi_bw_rr_scheduler_if #(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ID_IN   = 4,
  parameter int AXI_ID_OUT  = 6,
  parameter int AXI_USER_W  = 6
);
  logic [N_INIT_PORT-1:0][AXI_ID_OUT-1:0] bid_i;
  logic [N_INIT_PORT-1:0][1:0]            bresp_i;
  logic [N_INIT_PORT-1:0][AXI_USER_W-1:0] buser_i;
  logic [N_INIT_PORT-1:0]                 bvalid_i;
  logic [N_INIT_PORT-1:0]                 bready_o;
  logic [AXI_ID_IN-1:0]                   bid_o;
  logic [1:0]                             bresp_o;
  logic [AXI_USER_W-1:0]                  buser_o;
  logic                                   bvalid_o;
  logic                                   bready_i;
  logic                                   incr_req_i;
  logic                                   full_counter_o;
  logic                                   outstanding_trans_o;

  modport slave (
    input  bid_i, bresp_i, buser_i, bvalid_i, bready_i, incr_req_i,
    output bready_o, bid_o, bresp_o, buser_o, bvalid_o, full_counter_o, outstanding_trans_o
  );

  modport master (
    output bid_i, bresp_i, buser_i, bvalid_i, bready_i, incr_req_i,
    input  bready_o, bid_o, bresp_o, buser_o, bvalid_o, full_counter_o, outstanding_trans_o
  );
endinterface

// File: rtl/axi_bw_rr_scheduler.sv
// rtl/axi_bw_rr_scheduler.sv - round-robin B-channel merge into a one-entry slice with outstanding counter
// Optional stall counter output enabled by macro AXI_BW_SCHED_STATS_EN.
module axi_bw_rr_scheduler #(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ID_IN   = 4,
  parameter int AXI_ID_OUT  = 6,
  parameter int AXI_USER_W  = 6,
  parameter int CNT_W       = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef AXI_BW_SCHED_STATS_EN
  output logic [15:0]           stall_cnt_o,
`endif
  axi_bw_rr_scheduler_if.slave  bus
);
  localparam int PTR_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

  typedef enum logic {S_EMPTY, S_FULL} slice_state_t;

  slice_state_t             state, state_nxt;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         win;
  logic                     found;
  logic                     accept;
  logic                     take;
  logic                     drain;
  logic [N_INIT_PORT-1:0]   ready_v;
  logic [AXI_ID_OUT-1:0]    win_bid;
  logic [AXI_ID_IN-1:0]     bid_q;
  logic [1:0]               bresp_q;
  logic [AXI_USER_W-1:0]    buser_q;
  logic [CNT_W-1:0]         cnt;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_INIT_PORT; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= N_INIT_PORT) idx = idx - N_INIT_PORT;
      if (!found && bus.bvalid_i[idx]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  // The slice takes a new beat when empty, or when its current beat leaves this cycle.
  always_comb begin
    state_nxt = state;
    accept    = (state == S_EMPTY) || bus.bready_i;
    take      = accept && found && rst_n;
    drain     = (state == S_FULL) && bus.bready_i;
    ready_v   = '0;
    win_bid   = bus.bid_i[win];
    if (take) begin
      ready_v[win] = 1'b1;
      state_nxt    = S_FULL;
    end else if (drain) begin
      state_nxt    = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_EMPTY;
      rr_ptr  <= '0;
      bid_q   <= '0;
      bresp_q <= '0;
      buser_q <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        bid_q   <= win_bid[AXI_ID_IN-1:0];
        bresp_q <= bus.bresp_i[win];
        buser_q <= bus.buser_i[win];
        rr_ptr  <= (win == PTR_W'(N_INIT_PORT - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  // Simultaneous increment and decrement cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (bus.incr_req_i && !drain) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
    end else if (drain && !bus.incr_req_i) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

`ifdef AXI_BW_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if ((state == S_FULL) && !bus.bready_i && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

  assign bus.bready_o            = ready_v;
  assign bus.bvalid_o            = (state == S_FULL);
  assign bus.bid_o               = bid_q;
  assign bus.bresp_o             = bresp_q;
  assign bus.buser_o             = buser_q;
  assign bus.full_counter_o      = (cnt == '1);
  assign bus.outstanding_trans_o = (cnt != '0);
endmodule

// File: tb/tb_axi_bw_rr_scheduler.sv
// tb/tb_axi_bw_rr_scheduler.sv - vector table plus scoreboard bench for axi_bw_rr_scheduler
module tb_axi_bw_rr_scheduler;
  localparam int N  = 4;
  localparam int IDI = 4;
  localparam int IDO = 6;
  localparam int UW = 6;
  localparam int CW = 10;

  typedef struct packed {
    logic [IDI-1:0] bid;
    logic [1:0]     bresp;
    logic [UW-1:0]  buser;
  } beat_t;

  typedef struct {
    logic [N-1:0] valid;
    logic         rdy;
    logic [N-1:0] exp_ready;
    logic         exp_valid;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  beat_t sb[$];
  vec_t  vecs[13];

`ifdef AXI_BW_SCHED_STATS_EN
  logic [15:0] stall_cnt;
`endif

  axi_bw_rr_scheduler_if #(.N_INIT_PORT(N), .AXI_ID_IN(IDI), .AXI_ID_OUT(IDO), .AXI_USER_W(UW)) bus ();

  axi_bw_rr_scheduler #(.N_INIT_PORT(N), .AXI_ID_IN(IDI), .AXI_ID_OUT(IDO),
                        .AXI_USER_W(UW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AXI_BW_SCHED_STATS_EN
    .stall_cnt_o (stall_cnt),
`endif
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    bus.bvalid_i = '0;
    bus.bready_i = 1'b0;
    bus.incr_req_i = 1'b0;
    repeat (cycles) cyc();
    rst_n = 1'b1;
  endtask

  // Output beats are compared against what the bench saw granted one or more cycles earlier.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.bvalid_o && bus.bready_i) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("sb_beat", {14'd0, bus.bid_o, bus.bresp_o, bus.buser_o}, {14'd0, e});
        end
      end
      for (int p = 0; p < N; p++) begin
        if (bus.bready_o[p] && bus.bvalid_i[p]) begin
          logic [IDO-1:0] full_id;
          full_id = bus.bid_i[p];
          sb.push_back('{bid: full_id[IDI-1:0], bresp: bus.bresp_i[p], buser: bus.buser_i[p]});
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < N; p++) begin
      bus.bid_i[p]   = IDO'(6'h11 + 6'(p * 7));
      bus.bresp_i[p] = 2'(p);
      bus.buser_i[p] = UW'(6'h30 + 6'(p * 3));
    end
    bus.bid_i[2] = 6'h2B;

    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    vecs[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b0};
    vecs[8]  = '{4'b1010, 1'b1, 4'b1000, 1'b1};
    vecs[9]  = '{4'b1010, 1'b0, 4'b0000, 1'b1};
    vecs[10] = '{4'b1010, 1'b1, 4'b0010, 1'b1};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0};

    do_reset(2);
    bus.bvalid_i = 4'b1111;
    @(negedge clk);
    chk("reset_bvalid_o", 32'(bus.bvalid_o), 32'd0);
    chk("reset_full_counter", 32'(bus.full_counter_o), 32'd0);
    chk("reset_outstanding", 32'(bus.outstanding_trans_o), 32'd0);
    chk("reset_bid_o", 32'(bus.bid_o), 32'd0);
    chk("reset_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    cyc();

    do_reset(1);
    for (int i = 0; i < 13; i++) begin
      bus.bvalid_i = vecs[i].valid;
      bus.bready_i = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_bready_o", i), 32'(bus.bready_o), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_bvalid_o", i), 32'(bus.bvalid_o), 32'(vecs[i].exp_valid));
      cyc();
    end

    do_reset(1);
    bus.bvalid_i = 4'b0100;
    bus.bready_i = 1'b0;
    @(negedge clk);
    chk("stall_first_grant", 32'(bus.bready_o), 32'h4);
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_bid_o", 32'(bus.bid_o), 32'hB);
      chk("stall_bready_o", 32'(bus.bready_o), 32'd0);
      chk("stall_bvalid_o", 32'(bus.bvalid_o), 32'd1);
      cyc();
    end
`ifdef AXI_BW_SCHED_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd5);
`endif
    bus.bvalid_i = '0;
    bus.bready_i = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    chk("stall_drained", 32'(bus.bvalid_o), 32'd0);

    do_reset(1);
    bus.incr_req_i = 1'b1;
    repeat (1022) cyc();
    @(negedge clk);
    chk("cnt_1022_not_full", 32'(bus.full_counter_o), 32'd0);
    cyc();
    bus.incr_req_i = 1'b0;
    @(negedge clk);
    chk("cnt_full", 32'(bus.full_counter_o), 32'd1);
    chk("cnt_full_outstanding", 32'(bus.outstanding_trans_o), 32'd1);
    bus.incr_req_i = 1'b1;
    cyc();
    bus.incr_req_i = 1'b0;
    @(negedge clk);
    chk("cnt_saturate", 32'(dut.cnt), 32'd1023);
    chk("cnt_saturate_full", 32'(bus.full_counter_o), 32'd1);

    do_reset(1);
    bus.incr_req_i = 1'b1;
    repeat (3) cyc();
    bus.incr_req_i = 1'b0;
    bus.bvalid_i = 4'b0001;
    bus.bready_i = 1'b0;
    cyc();
    bus.bvalid_i = '0;
    bus.bready_i = 1'b1;
    bus.incr_req_i = 1'b1;
    cyc();
    bus.incr_req_i = 1'b0;
    @(negedge clk);
    chk("cnt_incr_dec_hold", 32'(dut.cnt), 32'd3);
    bus.bvalid_i = 4'b0001;
    bus.bready_i = 1'b0;
    cyc();
    bus.bvalid_i = '0;
    bus.bready_i = 1'b1;
    cyc();
    @(negedge clk);
    chk("cnt_dec_only", 32'(dut.cnt), 32'd2);

    do_reset(1);
    bus.incr_req_i = 1'b1;
    cyc();
    bus.incr_req_i = 1'b0;
    bus.bvalid_i = 4'b0010;
    bus.bready_i = 1'b0;
    cyc();
    @(negedge clk);
    chk("mid_full_before_reset", 32'(bus.bvalid_o), 32'd1);
    chk("mid_rr_before_reset", 32'(dut.rr_ptr), 32'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("in_reset_bready_o", 32'(bus.bready_o), 32'd0);
    cyc();
    rst_n = 1'b1;
    bus.bvalid_i = '0;
    @(negedge clk);
    chk("post_reset_bvalid_o", 32'(bus.bvalid_o), 32'd0);
    chk("post_reset_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    chk("post_reset_outstanding", 32'(bus.outstanding_trans_o), 32'd0);
    chk("post_reset_bid_o", 32'(bus.bid_o), 32'd0);
    cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
